vga_tile_scanout: RTL and testbench

- Downstream consumer of the VIDEORAM read port. Generates 640x480@60 VGA timing on CLK_VGA (25 MHz pixel clock).
- Maps each visible pixel to one of 16 screen tiles, drives the RAM read address, and waits out the RAM read latency.
- Converts the returned 8-bit tile word into 1-bit R/G/B plus HSYNC/VSYNC, all pipeline-aligned. Sits between VIDEORAM and the board VGA pins.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_tile_scanout_if.sv | 19 +
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_tile_scanout.sv | 208 ++++++++++++++++++++
 tb/tb_vga_tile_scanout.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA tile scanout block.
//   - Default 640x480@60 timing and the frame totals / sync windows derived from it.
//   - vga_ctl_t: per-pixel control bits carried down the scanout pipeline so that
//     blanking, syncs and the tile border flag stay aligned with the RAM read data.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_TILE_W   = 160;
  localparam int unsigned DEF_TILE_H   = 120;
  localparam int unsigned DEF_GRID_W   = 4;
  localparam int unsigned DEF_RD_LAT   = 2;

  localparam int unsigned H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

  // hs/vs are active-high here; the pins are inverted at the output register.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic border;
  } vga_ctl_t;

endpackage

// File: rtl/vga_tile_scanout_if.sv
// VIDEORAM read port as seen by the scanout block.
//   RAM_RADDR : 4-bit tile address, driven by the scanout (master)
//   RAM_RDATA : 8-bit tile word, returned by the RAM (slave) a fixed latency later
interface vga_tile_scanout_if;

  logic [3:0] RAM_RADDR;
  logic [7:0] RAM_RDATA;

  modport master (
    output RAM_RADDR,
    input  RAM_RDATA
  );

  modport slave (
    input  RAM_RADDR,
    output RAM_RDATA
  );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep per-pixel control bits aligned with the
// RAM read latency.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset, clears every stage to 0
//   d_i    : input word
//   q_o    : d_i delayed by DEPTH cycles
module vga_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_tile_scanout.sv
// VGA tile scanout: generates VGA timing, maps each visible pixel to one of 16 screen
// tiles, reads the tile word from VIDEORAM and drives 1-bit RGB plus syncs.
//   CLK_VGA     : pixel clock
//   RST_N       : synchronous active-low reset
//   ram         : VIDEORAM read port (RAM_RADDR out, RAM_RDATA in, RD_LAT cycles apart)
//   VGA_R/G/B   : registered pixel colour, 0 outside the visible area
//   VGA_HSYNC   : horizontal sync, active low
//   VGA_VSYNC   : vertical sync, active low
//   FRAME_START : one-cycle pulse while the counters sit at (0,0)
//   VBLANK      : high while the line counter is in vertical blanking (not delayed)
// Counters to pins take RD_LAT+2 cycles: address register, RAM latency, output register.
module vga_tile_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned TILE_W   = DEF_TILE_W,
  parameter int unsigned TILE_H   = DEF_TILE_H,
  parameter int unsigned GRID_W   = DEF_GRID_W,
  parameter int unsigned RD_LAT   = DEF_RD_LAT
) (
  input  logic               CLK_VGA,
  input  logic               RST_N,
  vga_tile_scanout_if.master ram,
  output logic               VGA_R,
  output logic               VGA_G,
  output logic               VGA_B,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic               FRAME_START,
  output logic               VBLANK
);

  localparam int unsigned HTotal  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;
  localparam int unsigned HW      = $clog2(HTotal);
  localparam int unsigned VW      = $clog2(VTotal);
  localparam int unsigned TXW     = $clog2(TILE_W);
  localparam int unsigned TYW     = $clog2(TILE_H);
  // Address register plus RAM latency; the output register adds the final stage.
  localparam int unsigned CtlDepth = RD_LAT + 1;

  // Low for the first edge out of reset so the counters restart at (0,0) on that edge.
  logic           run_q;
  logic [HW-1:0]  h_cnt_q, h_cnt_d;
  logic [VW-1:0]  v_cnt_q, v_cnt_d;
  logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
  logic [TYW-1:0] ty_cnt_q, ty_cnt_d;
  logic [1:0]     tile_col_q, tile_col_d;
  logic [1:0]     tile_row_q, tile_row_d;
  logic           h_wrap, v_wrap;

  logic           frame_start_q, vblank_q;
  logic [3:0]     raddr_q;
  logic [2:0]     rgb_q, rgb_d;
  logic           hsync_q, vsync_q;

  vga_ctl_t       ctl0, ctl_dly;
  logic [3:0]     unused_rdata_hi;

  // ---------------------------------------------------------------------------
  // Counters and tile tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    ty_cnt_d   = ty_cnt_q;
    tile_col_d = tile_col_q;
    tile_row_d = tile_row_q;
    h_wrap     = (h_cnt_q == HW'(HTotal - 1));
    v_wrap     = (v_cnt_q == VW'(VTotal - 1));

    if (run_q) begin
      if (h_wrap) begin
        h_cnt_d    = '0;
        tx_cnt_d   = '0;
        tile_col_d = '0;
        if (v_wrap) begin
          v_cnt_d    = '0;
          ty_cnt_d   = '0;
          tile_row_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
          // Only step within the visible lines so ty/row never run past the last tile.
          if (v_cnt_q < VW'(V_ACTIVE - 1)) begin
            if (ty_cnt_q == TYW'(TILE_H - 1)) begin
              ty_cnt_d   = '0;
              tile_row_d = tile_row_q + 1'b1;
            end else begin
              ty_cnt_d = ty_cnt_q + 1'b1;
            end
          end
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        if (h_cnt_q < HW'(H_ACTIVE - 1)) begin
          if (tx_cnt_q == TXW'(TILE_W - 1)) begin
            tx_cnt_d   = '0;
            tile_col_d = (tile_col_q == 2'(GRID_W - 1)) ? '0 : tile_col_q + 1'b1;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK_VGA) begin
    if (!RST_N) begin
      run_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      tx_cnt_q      <= '0;
      ty_cnt_q      <= '0;
      tile_col_q    <= '0;
      tile_row_q    <= '0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      ty_cnt_q      <= ty_cnt_d;
      tile_col_q    <= tile_col_d;
      tile_row_q    <= tile_row_d;
      // Registered from next-state so both flags line up with the counter values.
      frame_start_q <= (h_cnt_d == '0) && (v_cnt_d == '0);
      vblank_q      <= (v_cnt_d >= VW'(V_ACTIVE));
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: decode the counter position
  // ---------------------------------------------------------------------------
  always_comb begin
    ctl0 = '0;
    // The restart cycle carries no pixel, keeping the first RD_LAT+2 outputs blank.
    if (run_q) begin
      ctl0.active = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
      ctl0.hs     = (h_cnt_q >= HW'(HsStart)) && (h_cnt_q < HW'(HsEnd));
      ctl0.vs     = (v_cnt_q >= VW'(VsStart)) && (v_cnt_q < VW'(VsEnd));
      ctl0.border = (tx_cnt_q == '0) || (tx_cnt_q == TXW'(TILE_W - 1)) ||
                    (ty_cnt_q == '0) || (ty_cnt_q == TYW'(TILE_H - 1));
    end
  end

  vga_delay_line #(
    .DEPTH (CtlDepth),
    .WIDTH ($bits(vga_ctl_t))
  ) u_ctl_delay (
    .clk_i  (CLK_VGA),
    .rst_ni (RST_N),
    .d_i    (ctl0),
    .q_o    (ctl_dly)
  );

  // ---------------------------------------------------------------------------
  // Colour: tile word bits [2:0] are {B,G,R}; bit 3 inverts the colour on tile edges
  // ---------------------------------------------------------------------------
  always_comb begin
    rgb_d = '0;
    if (ctl_dly.active) begin
      rgb_d = ram.RAM_RDATA[2:0] ^ {3{ram.RAM_RDATA[3] & ctl_dly.border}};
    end
  end

  assign unused_rdata_hi = ram.RAM_RDATA[7:4];

  // Stage 1 address register and the pin register.
  always_ff @(posedge CLK_VGA) begin
    if (!RST_N) begin
      raddr_q <= '0;
      rgb_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      // Outside the visible area the address holds its last value.
      if (ctl0.active) begin
        raddr_q <= {tile_row_q, tile_col_q};
      end
      rgb_q   <= rgb_d;
      hsync_q <= ~ctl_dly.hs;
      vsync_q <= ~ctl_dly.vs;
    end
  end

  assign ram.RAM_RADDR = raddr_q;
  assign VGA_R         = rgb_q[0];
  assign VGA_G         = rgb_q[1];
  assign VGA_B         = rgb_q[2];
  assign VGA_HSYNC     = hsync_q;
  assign VGA_VSYNC     = vsync_q;
  assign FRAME_START   = frame_start_q;
  assign VBLANK        = vblank_q;

endmodule

// File: tb/tb_vga_tile_scanout.sv
// Scoreboard bench for vga_tile_scanout. Two instances share a clock: one with the
// full 640x480 timing (a few lines only) and one with a shrunken timing so that whole
// frames, vsync and every tile row are exercised quickly. Per cycle a producer pushes
// the expected pin values computed from the pixel position; a monitor pops and compares.
module tb_vga_tile_scanout;
  import vga_pkg::*;

  typedef struct packed {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    int tw; int th; int gw;
  } cfg_t;

  typedef struct packed {
    logic [2:0] rgb;   // {B,G,R}
    logic       hs;
    logic       vs;
    logic [3:0] raddr;
    logic       fs;
    logic       vb;
  } exp_t;

  localparam cfg_t CFG_F = '{640, 16, 96, 48, 480, 10, 2, 33, 160, 120, 4};
  localparam cfg_t CFG_S = '{40, 4, 8, 4, 24, 2, 2, 2, 10, 6, 4};
  localparam int PIPE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s_n = 1'b0;
  logic rst_f_n = 1'b0;
  logic done_s  = 1'b0;
  logic done_f  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  vga_tile_scanout_if ram_s ();
  vga_tile_scanout_if ram_f ();

  logic r_s, g_s, b_s, hs_s, vs_s, fs_s, vb_s;
  logic r_f, g_f, b_f, hs_f, vs_f, fs_f, vb_f;

  vga_tile_scanout #(
    .H_ACTIVE (CFG_S.ha), .H_FP (CFG_S.hfp), .H_SYNC (CFG_S.hsw), .H_BP (CFG_S.hbp),
    .V_ACTIVE (CFG_S.va), .V_FP (CFG_S.vfp), .V_SYNC (CFG_S.vsw), .V_BP (CFG_S.vbp),
    .TILE_W (CFG_S.tw), .TILE_H (CFG_S.th), .GRID_W (CFG_S.gw), .RD_LAT (2)
  ) dut_s (
    .CLK_VGA (clk), .RST_N (rst_s_n), .ram (ram_s),
    .VGA_R (r_s), .VGA_G (g_s), .VGA_B (b_s), .VGA_HSYNC (hs_s), .VGA_VSYNC (vs_s),
    .FRAME_START (fs_s), .VBLANK (vb_s)
  );

  vga_tile_scanout dut_f (
    .CLK_VGA (clk), .RST_N (rst_f_n), .ram (ram_f),
    .VGA_R (r_f), .VGA_G (g_f), .VGA_B (b_f), .VGA_HSYNC (hs_f), .VGA_VSYNC (vs_f),
    .FRAME_START (fs_f), .VBLANK (vb_f)
  );

  // VIDEORAM models: address registered, data registered -> 2 cycles.
  logic [7:0] mem_s [16];
  logic [7:0] mem_f [16];
  logic [3:0] a1_s, a1_f;
  always @(posedge clk) begin
    a1_s            <= ram_s.RAM_RADDR;
    ram_s.RAM_RDATA <= mem_s[a1_s];
    a1_f            <= ram_f.RAM_RADDR;
    ram_f.RAM_RDATA <= mem_f[a1_f];
  end

  // Expected pins in the k-th cycle after reset release (pixel position k-1).
  // lt is the tile of the most recent visible pixel seen before this cycle.
  function automatic void model(input cfg_t c, input int k, input logic [7:0] m [16],
                                inout logic [3:0] lt, output exp_t e);
    int ht, vt, p, h, v, q, hq, vq;
    logic act, brd;
    logic [7:0] w;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    p  = k - 1;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.raddr = lt;
    e.fs    = (p % (ht * vt)) == 0;
    e.vb    = v >= c.va;
    if (h < c.ha && v < c.va) lt = 4'((v / c.th) * c.gw + h / c.tw);
    if (p < PIPE) begin
      e.rgb = 3'b000;
      e.hs  = 1'b1;
      e.vs  = 1'b1;
    end else begin
      q   = p - PIPE;
      hq  = q % ht;
      vq  = (q / ht) % vt;
      act = hq < c.ha && vq < c.va;
      brd = (hq % c.tw == 0) || (hq % c.tw == c.tw - 1) ||
            (vq % c.th == 0) || (vq % c.th == c.th - 1);
      e.rgb = 3'b000;
      if (act) begin
        w     = m[(vq / c.th) * c.gw + hq / c.tw];
        e.rgb = w[2:0] ^ {3{w[3] & brd}};
      end
      e.hs = !(hq >= c.ha + c.hfp && hq < c.ha + c.hfp + c.hsw);
      e.vs = !(vq >= c.va + c.vfp && vq < c.va + c.vfp + c.vsw);
    end
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = '{rgb: 3'b000, hs: 1'b1, vs: 1'b1, raddr: 4'h0, fs: 1'b0, vb: 1'b0};
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [2:0] rgb,
                         input logic hs, input logic vs, input logic [3:0] ra,
                         input logic fs, input logic vb);
    chk({tag, ".rgb"}, 8'(rgb), 8'(e.rgb));
    chk({tag, ".hsync"}, 8'(hs), 8'(e.hs));
    chk({tag, ".vsync"}, 8'(vs), 8'(e.vs));
    chk({tag, ".raddr"}, 8'(ra), 8'(e.raddr));
    chk({tag, ".frame_start"}, 8'(fs), 8'(e.fs));
    chk({tag, ".vblank"}, 8'(vb), 8'(e.vb));
  endtask

  // Producers: one expected entry per clock edge.
  exp_t q_s[$];
  exp_t q_f[$];

  initial begin
    int k_s, k_f;
    logic [3:0] lt_s, lt_f;
    exp_t e;
    k_s  = 0;
    k_f  = 0;
    lt_s = '0;
    lt_f = '0;
    forever begin
      @(posedge clk);
      if (!rst_s_n) begin
        k_s  = 0;
        lt_s = '0;
        q_s.push_back(reset_exp());
      end else begin
        k_s++;
        model(CFG_S, k_s, mem_s, lt_s, e);
        q_s.push_back(e);
      end
      if (!rst_f_n) begin
        k_f  = 0;
        lt_f = '0;
        q_f.push_back(reset_exp());
      end else begin
        k_f++;
        model(CFG_F, k_f, mem_f, lt_f, e);
        q_f.push_back(e);
      end
    end
  end

  // Monitor: compare away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        compare("small", e, {b_s, g_s, r_s}, hs_s, vs_s, ram_s.RAM_RADDR, fs_s, vb_s);
      end
      if (q_f.size() > 0) begin
        e = q_f.pop_front();
        compare("full", e, {b_f, g_f, r_f}, hs_f, vs_f, ram_f.RAM_RADDR, fs_f, vb_f);
      end
    end
  end

  // Shrunken timing: directed tile-5 border frame, then randomized words and resets.
  initial begin
    int frame;
    frame = (CFG_S.ha + CFG_S.hfp + CFG_S.hsw + CFG_S.hbp) *
            (CFG_S.va + CFG_S.vfp + CFG_S.vsw + CFG_S.vbp);
    for (int i = 0; i < 16; i++) mem_s[i] = 8'h05;
    mem_s[5] = 8'h0A;
    rst_s_n  = 1'b0;
    repeat (10) @(negedge clk);
    rst_s_n = 1'b1;
    repeat (2 * frame + 50) @(negedge clk);
    for (int ph = 0; ph < 6; ph++) begin
      rst_s_n = 1'b0;
      for (int i = 0; i < 16; i++) mem_s[i] = 8'($urandom);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst_s_n = 1'b1;
      repeat ($urandom_range(800, 2600)) @(negedge clk);
    end
    done_s = 1'b1;
  end

  // Full timing: first lines after reset, then a mid-line reset and restart.
  initial begin
    $display("default timing: H_TOTAL=%0d V_TOTAL=%0d hsync %0d..%0d vsync %0d..%0d",
             H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END);
    for (int i = 0; i < 16; i++) mem_f[i] = 8'h05;
    mem_f[5] = 8'h0A;
    rst_f_n  = 1'b0;
    repeat (10) @(negedge clk);
    rst_f_n = 1'b1;
    // Stops after the pixel at h=300 of line 2.
    repeat (2 * 800 + 301) @(negedge clk);
    rst_f_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_f_n = 1'b1;
    repeat (1800) @(negedge clk);
    done_f = 1'b1;
  end

  initial begin
    wait (done_s && done_f);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
